// File: rtl/inst_encoder_loader_pkg.sv
// ============================================================================
// Module      : inst_encoder_loader_pkg
// Description : ISA constants shared by the instruction encoder/loader:
//               opcode values, field bit positions and the word-format enum.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package inst_encoder_loader_pkg;

  // Opcodes
  localparam logic [4:0] OP_ALU  = 5'b00000;
  localparam logic [4:0] OP_J    = 5'b00001;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_JAL  = 5'b00011;
  localparam logic [4:0] OP_JR   = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_SETX = 5'b10101;
  localparam logic [4:0] OP_BEX  = 5'b10110;

  // Field positions (LSB of each field) and widths
  localparam int REG_W     = 5;
  localparam int OP_LSB    = 27;
  localparam int RD_LSB    = 22;
  localparam int RS_LSB    = 17;
  localparam int RT_LSB    = 12;
  localparam int SHAMT_LSB = 7;
  localparam int ALUOP_LSB = 2;
  localparam int IMM_W     = 17;
  localparam int TARGET_W  = 27;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_JI  = 3'd2,
    FMT_JII = 3'd3,
    FMT_BAD = 3'd4
  } fmt_e;

endpackage

`default_nettype wire

// File: rtl/inst_encoder_loader_if.sv
// ============================================================================
// Module      : inst_encoder_loader_if
// Description : Bundles the loader's control, field stream, imem write port
//               and status signals.
//               slave  : the loader (consumes start/fields, drives imem/status)
//               master : the boot/test agent feeding it
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface inst_encoder_loader_if #(
  parameter int ADDR_W = 12
);
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [4:0]        in_opcode;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_shamt;
  logic [4:0]        in_aluop;
  logic [16:0]       in_imm;
  logic [26:0]       in_target;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_data;
  logic              busy;
  logic              done;
  logic              err_opcode;
  logic              err_full;
  logic [ADDR_W:0]   count;

  modport slave (
    input  start, in_valid, in_last, in_opcode, in_rd, in_rs, in_rt,
           in_shamt, in_aluop, in_imm, in_target,
    output in_ready, imem_we, imem_addr, imem_data, busy, done,
           err_opcode, err_full, count
  );

  modport master (
    output start, in_valid, in_last, in_opcode, in_rd, in_rs, in_rt,
           in_shamt, in_aluop, in_imm, in_target,
    input  in_ready, imem_we, imem_addr, imem_data, busy, done,
           err_opcode, err_full, count
  );
endinterface

`default_nettype wire

// File: rtl/inst_encoder_loader_pack.sv
// ============================================================================
// Module      : inst_encoder_loader_pack
// Description : Combinational packer: opcode + decoded fields -> 32-bit ISA
//               word and its format. Unsupported opcodes give FMT_BAD and 0.
// Ports       : opcode_i, rd_i, rs_i, rt_i, shamt_i, aluop_i, imm_i,
//               target_i -> word_o (32b), fmt_o (fmt_e)
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module inst_encoder_loader_pack
  import inst_encoder_loader_pkg::*;
(
  input  logic [4:0]  opcode_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  shamt_i,
  input  logic [4:0]  aluop_i,
  input  logic [16:0] imm_i,
  input  logic [26:0] target_i,
  output logic [31:0] word_o,
  output fmt_e        fmt_o
);

  always_comb begin
    fmt_o = FMT_BAD;
    case (opcode_i)
      OP_ALU:                                 fmt_o = FMT_R;
      OP_ADDI, OP_SW, OP_LW, OP_BNE, OP_BLT:  fmt_o = FMT_I;
      OP_J, OP_JAL, OP_BEX, OP_SETX:          fmt_o = FMT_JI;
      OP_JR:                                  fmt_o = FMT_JII;
      default:                                fmt_o = FMT_BAD;
    endcase
  end

  // Only the fields belonging to the selected format are placed; everything
  // else stays zero so stray field values never leak into the word.
  always_comb begin
    word_o = '0;
    case (fmt_o)
      FMT_R: begin
        word_o[OP_LSB    +: REG_W] = opcode_i;
        word_o[RD_LSB    +: REG_W] = rd_i;
        word_o[RS_LSB    +: REG_W] = rs_i;
        word_o[RT_LSB    +: REG_W] = rt_i;
        word_o[SHAMT_LSB +: REG_W] = shamt_i;
        word_o[ALUOP_LSB +: REG_W] = aluop_i;
      end
      FMT_I: begin
        word_o[OP_LSB +: REG_W] = opcode_i;
        word_o[RD_LSB +: REG_W] = rd_i;
        word_o[RS_LSB +: REG_W] = rs_i;
        word_o[0      +: IMM_W] = imm_i;
      end
      FMT_JI: begin
        word_o[OP_LSB +: REG_W]    = opcode_i;
        word_o[0      +: TARGET_W] = target_i;
      end
      FMT_JII: begin
        word_o[OP_LSB +: REG_W] = opcode_i;
        word_o[RD_LSB +: REG_W] = rd_i;
      end
      default: word_o = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/inst_encoder_loader.sv
// ============================================================================
// Module      : inst_encoder_loader
// Description : Accepts decoded instruction bundles, packs them into 32-bit
//               ISA words and writes them sequentially into imem starting at
//               BASE_ADDR, optionally padding PAD_NOPS zero words at the end.
// Ports       : clock, reset (async, active high)
//               bus (slave): start, in_* stream, imem_we/addr/data,
//                            busy, done, err_opcode, err_full, count
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module inst_encoder_loader
  import inst_encoder_loader_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 4096,
  parameter int PAD_NOPS  = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  inst_encoder_loader_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_PAD  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [ADDR_W-1:0] c_base     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   c_depth    = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   c_one      = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   c_pad_last = (ADDR_W+1)'((PAD_NOPS > 0) ? PAD_NOPS - 1 : 0);
  localparam bit                c_has_pad  = (PAD_NOPS > 0);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W:0]   pad_q, pad_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic              err_op_q, err_op_d;
  logic              err_full_q, err_full_d;

  logic [31:0]       w_word;
  fmt_e              w_fmt;
  logic              w_full;
  logic              w_ready;
  logic              w_accept;
  logic [ADDR_W-1:0] w_ptr;

  inst_encoder_loader_pack u_pack (
    .opcode_i (bus.in_opcode),
    .rd_i     (bus.in_rd),
    .rs_i     (bus.in_rs),
    .rt_i     (bus.in_rt),
    .shamt_i  (bus.in_shamt),
    .aluop_i  (bus.in_aluop),
    .imm_i    (bus.in_imm),
    .target_i (bus.in_target),
    .word_o   (w_word),
    .fmt_o    (w_fmt)
  );

  // count already includes a write issued on the previous edge, so the
  // full check always sees every word committed so far.
  assign w_full   = (count_q == c_depth);
  assign w_ready  = (state_q == S_LOAD) && !w_full;
  assign w_accept = bus.in_valid && w_ready;
  assign w_ptr    = c_base + count_q[ADDR_W-1:0];

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    pad_d      = pad_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    err_op_d   = err_op_q;
    err_full_d = err_full_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d    = S_LOAD;
          count_d    = '0;
          pad_d      = '0;
          err_op_d   = 1'b0;
          err_full_d = 1'b0;
        end
      end
      S_LOAD: begin
        if (w_full && bus.in_valid) begin
          err_full_d = 1'b1;
          state_d    = S_DONE;
        end else if (w_accept) begin
          if (w_fmt != FMT_BAD) begin
            we_d    = 1'b1;
            addr_d  = w_ptr;
            data_d  = w_word;
            count_d = count_q + c_one;
          end else begin
            err_op_d = 1'b1;
          end
          if (bus.in_last) begin
            state_d = c_has_pad ? S_PAD : S_DONE;
          end
        end
      end
      S_PAD: begin
        if (w_full) begin
          state_d = S_DONE;
        end else begin
          we_d    = 1'b1;
          addr_d  = w_ptr;
          data_d  = '0;
          count_d = count_q + c_one;
          pad_d   = pad_q + c_one;
          if (pad_q == c_pad_last) begin
            state_d = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      pad_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= c_base;
      data_q     <= '0;
      err_op_q   <= 1'b0;
      err_full_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      pad_q      <= pad_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      err_op_q   <= err_op_d;
      err_full_q <= err_full_d;
    end
  end

  assign bus.in_ready   = w_ready;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_data  = data_q;
  assign bus.busy       = (state_q == S_LOAD) || (state_q == S_PAD);
  assign bus.done       = (state_q == S_DONE);
  assign bus.err_opcode = err_op_q;
  assign bus.err_full   = err_full_q;
  assign bus.count      = count_q;

endmodule

`default_nettype wire

// File: tb/tb_inst_encoder_loader.sv
// ============================================================================
// Module      : tb_inst_encoder_loader
// Description : Directed self-checking bench for inst_encoder_loader. Three
//               instances share one stimulus stream:
//                 d0 : defaults (BASE 0, DEPTH 4096, no pad)
//                 d1 : BASE_ADDR 16, PAD_NOPS 2
//                 d2 : DEPTH 2
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_inst_encoder_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [4:0]  in_opcode = '0, in_rd = '0, in_rs = '0, in_rt = '0;
  logic [4:0]  in_shamt = '0, in_aluop = '0;
  logic [16:0] in_imm = '0;
  logic [26:0] in_target = '0;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  inst_encoder_loader_if #(.ADDR_W(12)) i0 ();
  inst_encoder_loader_if #(.ADDR_W(12)) i1 ();
  inst_encoder_loader_if #(.ADDR_W(12)) i2 ();

  assign i0.start = start;     assign i1.start = start;     assign i2.start = start;
  assign i0.in_valid = in_valid; assign i1.in_valid = in_valid; assign i2.in_valid = in_valid;
  assign i0.in_last = in_last; assign i1.in_last = in_last; assign i2.in_last = in_last;
  assign i0.in_opcode = in_opcode; assign i1.in_opcode = in_opcode; assign i2.in_opcode = in_opcode;
  assign i0.in_rd = in_rd;     assign i1.in_rd = in_rd;     assign i2.in_rd = in_rd;
  assign i0.in_rs = in_rs;     assign i1.in_rs = in_rs;     assign i2.in_rs = in_rs;
  assign i0.in_rt = in_rt;     assign i1.in_rt = in_rt;     assign i2.in_rt = in_rt;
  assign i0.in_shamt = in_shamt; assign i1.in_shamt = in_shamt; assign i2.in_shamt = in_shamt;
  assign i0.in_aluop = in_aluop; assign i1.in_aluop = in_aluop; assign i2.in_aluop = in_aluop;
  assign i0.in_imm = in_imm;   assign i1.in_imm = in_imm;   assign i2.in_imm = in_imm;
  assign i0.in_target = in_target; assign i1.in_target = in_target; assign i2.in_target = in_target;

  inst_encoder_loader #(.ADDR_W(12), .BASE_ADDR(0), .DEPTH(4096), .PAD_NOPS(0))
    d0 (.clock(clock), .reset(reset), .bus(i0));
  inst_encoder_loader #(.ADDR_W(12), .BASE_ADDR(16), .DEPTH(4096), .PAD_NOPS(2))
    d1 (.clock(clock), .reset(reset), .bus(i1));
  inst_encoder_loader #(.ADDR_W(12), .BASE_ADDR(0), .DEPTH(2), .PAD_NOPS(0))
    d2 (.clock(clock), .reset(reset), .bus(i2));

  // Advance to 1 ns after the next rising edge: outputs are stable there
  // and new inputs set here are sampled at the following edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] sh, input logic [4:0] al,
                       input logic [16:0] im, input logic [26:0] tg, input logic last);
    in_valid = 1'b1; in_opcode = op; in_rd = rd; in_rs = rs; in_rt = rt;
    in_shamt = sh; in_aluop = al; in_imm = im; in_target = tg; in_last = last;
  endtask

  task automatic idle_bus();
    in_valid = 1'b0; in_last = 1'b0; in_opcode = '0; in_rd = '0; in_rs = '0;
    in_rt = '0; in_shamt = '0; in_aluop = '0; in_imm = '0; in_target = '0;
  endtask

  task automatic apply_reset();
    idle_bus();
    start = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    tests++; if ({i0.in_ready, i0.imem_we, i0.busy, i0.done, i0.err_opcode, i0.err_full} !== 6'b0) begin
      fails++; $display("FAIL reset_flags: got %b expected 000000",
        {i0.in_ready, i0.imem_we, i0.busy, i0.done, i0.err_opcode, i0.err_full}); end
    tests++; if (i0.imem_addr !== 12'd0 || i0.imem_data !== 32'd0 || i0.count !== 13'd0) begin
      fails++; $display("FAIL reset_regs: got addr %0d data %h count %0d expected 0 0 0",
        i0.imem_addr, i0.imem_data, i0.count); end
    tests++; if (i1.imem_addr !== 12'd16) begin
      fails++; $display("FAIL reset_base_addr: got %0d expected 16", i1.imem_addr); end
  endtask

  task automatic test_single_r();
    apply_reset();
    pulse_start();
    tests++; if (i0.busy !== 1'b1 || i0.in_ready !== 1'b1) begin
      fails++; $display("FAIL single_load_state: got busy %b ready %b expected 1 1", i0.busy, i0.in_ready); end
    drive(5'b00000, 5'd3, 5'd1, 5'd2, 5'd0, 5'd0, 17'd0, 27'd0, 1'b1);
    tick();
    idle_bus();
    tests++; if (i0.imem_we !== 1'b1 || i0.imem_addr !== 12'd0 || i0.imem_data !== 32'h00C22000) begin
      fails++; $display("FAIL single_write: got we %b addr %0d data %h expected 1 0 00c22000",
        i0.imem_we, i0.imem_addr, i0.imem_data); end
    tests++; if (i0.done !== 1'b1 || i0.count !== 13'd1) begin
      fails++; $display("FAIL single_done: got done %b count %0d expected 1 1", i0.done, i0.count); end
    tick();
    tests++; if (i0.imem_we !== 1'b0) begin
      fails++; $display("FAIL single_we_drop: got %b expected 0", i0.imem_we); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_data [4];
    exp_data[0] = 32'h01040190; exp_data[1] = 32'h2941FFFF;
    exp_data[2] = 32'h08000064; exp_data[3] = 32'h27C00000;
    apply_reset();
    pulse_start();
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: drive(5'b00000, 5'd4, 5'd2, 5'd0, 5'd3, 5'd4, 17'd0, 27'd0, 1'b0);
        1: drive(5'b00101, 5'd5, 5'd0, 5'd0, 5'd0, 5'd0, 17'h1FFFF, 27'd0, 1'b0);
        2: drive(5'b00001, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'd100, 1'b0);
        default: drive(5'b00100, 5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'd0, 1'b1);
      endcase
      tick();
      tests++; if (i0.imem_we !== 1'b1 || i0.imem_addr !== 12'(k) || i0.imem_data !== exp_data[k]) begin
        fails++; $display("FAIL burst_word%0d: got we %b addr %0d data %h expected 1 %0d %h",
          k, i0.imem_we, i0.imem_addr, i0.imem_data, k, exp_data[k]); end
    end
    idle_bus();
    tick();
    tests++; if (i0.imem_we !== 1'b0 || i0.count !== 13'd4 || i0.done !== 1'b1) begin
      fails++; $display("FAIL burst_end: got we %b count %0d done %b expected 0 4 1",
        i0.imem_we, i0.count, i0.done); end
  endtask

  // Stray values on fields outside each format must not reach the word.
  task automatic test_field_masking();
    logic [31:0] exp_data [3];
    exp_data[0] = 32'h41D30000; exp_data[1] = 32'hAFFFFFFF; exp_data[2] = 32'hB0000005;
    apply_reset();
    pulse_start();
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: drive(5'b01000, 5'd7, 5'd9, 5'd31, 5'd31, 5'd31, 17'h10000, 27'h7FFFFFF, 1'b0);
        1: drive(5'b10101, 5'd31, 5'd31, 5'd31, 5'd31, 5'd31, 17'h1FFFF, 27'h7FFFFFF, 1'b0);
        default: drive(5'b10110, 5'd31, 5'd31, 5'd31, 5'd31, 5'd31, 17'h1FFFF, 27'd5, 1'b1);
      endcase
      tick();
      tests++; if (i0.imem_data !== exp_data[k] || i0.imem_addr !== 12'(k)) begin
        fails++; $display("FAIL mask_word%0d: got addr %0d data %h expected %0d %h",
          k, i0.imem_addr, i0.imem_data, k, exp_data[k]); end
    end
    idle_bus();
  endtask

  task automatic test_pad();
    apply_reset();
    pulse_start();
    drive(5'b00101, 5'd1, 5'd2, 5'd0, 5'd0, 5'd0, 17'd5, 27'd0, 1'b1);
    tick();
    idle_bus();
    tests++; if (i1.imem_we !== 1'b1 || i1.imem_addr !== 12'd16 || i1.imem_data !== 32'h28440005 || i1.busy !== 1'b1) begin
      fails++; $display("FAIL pad_instr: got we %b addr %0d data %h busy %b expected 1 16 28440005 1",
        i1.imem_we, i1.imem_addr, i1.imem_data, i1.busy); end
    tick();
    tests++; if (i1.imem_we !== 1'b1 || i1.imem_addr !== 12'd17 || i1.imem_data !== 32'd0 || i1.done !== 1'b0) begin
      fails++; $display("FAIL pad_nop1: got we %b addr %0d data %h done %b expected 1 17 0 0",
        i1.imem_we, i1.imem_addr, i1.imem_data, i1.done); end
    tick();
    tests++; if (i1.imem_we !== 1'b1 || i1.imem_addr !== 12'd18 || i1.imem_data !== 32'd0 || i1.done !== 1'b1) begin
      fails++; $display("FAIL pad_nop2: got we %b addr %0d data %h done %b expected 1 18 0 1",
        i1.imem_we, i1.imem_addr, i1.imem_data, i1.done); end
    tick();
    tests++; if (i1.imem_we !== 1'b0 || i1.count !== 13'd3) begin
      fails++; $display("FAIL pad_end: got we %b count %0d expected 0 3", i1.imem_we, i1.count); end
  endtask

  task automatic test_bad_opcode();
    apply_reset();
    pulse_start();
    drive(5'b00000, 5'd1, 5'd1, 5'd1, 5'd0, 5'd0, 17'd0, 27'd0, 1'b0);
    tick();
    drive(5'b11111, 5'd9, 5'd9, 5'd9, 5'd9, 5'd9, 17'h1FFFF, 27'h7FFFFFF, 1'b0);
    tests++; if (i0.in_ready !== 1'b1) begin
      fails++; $display("FAIL bad_ready: got %b expected 1", i0.in_ready); end
    tick();
    tests++; if (i0.imem_we !== 1'b0 || i0.err_opcode !== 1'b1 || i0.count !== 13'd1) begin
      fails++; $display("FAIL bad_dropped: got we %b err %b count %0d expected 0 1 1",
        i0.imem_we, i0.err_opcode, i0.count); end
    drive(5'b00101, 5'd2, 5'd0, 5'd0, 5'd0, 5'd0, 17'd1, 27'd0, 1'b1);
    tick();
    idle_bus();
    tests++; if (i0.imem_we !== 1'b1 || i0.imem_addr !== 12'd1 || i0.imem_data !== 32'h28800001 || i0.count !== 13'd2) begin
      fails++; $display("FAIL bad_next: got we %b addr %0d data %h count %0d expected 1 1 28800001 2",
        i0.imem_we, i0.imem_addr, i0.imem_data, i0.count); end
  endtask

  task automatic test_full();
    apply_reset();
    pulse_start();
    drive(5'b00001, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'd1, 1'b0);
    tick();
    drive(5'b00001, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'd2, 1'b0);
    tick();
    tests++; if (i2.imem_addr !== 12'd1 || i2.count !== 13'd2 || i2.in_ready !== 1'b0) begin
      fails++; $display("FAIL full_second: got addr %0d count %0d ready %b expected 1 2 0",
        i2.imem_addr, i2.count, i2.in_ready); end
    drive(5'b00001, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'd3, 1'b0);
    tick();
    idle_bus();
    tests++; if (i2.imem_we !== 1'b0 || i2.err_full !== 1'b1 || i2.done !== 1'b1 || i2.count !== 13'd2) begin
      fails++; $display("FAIL full_err: got we %b err %b done %b count %0d expected 0 1 1 2",
        i2.imem_we, i2.err_full, i2.done, i2.count); end
    pulse_start();
    tests++; if (i2.err_full !== 1'b0 || i2.count !== 13'd0 || i2.busy !== 1'b1) begin
      fails++; $display("FAIL full_restart: got err %b count %0d busy %b expected 0 0 1",
        i2.err_full, i2.count, i2.busy); end
    drive(5'b00001, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'd7, 1'b1);
    tick();
    idle_bus();
    tests++; if (i2.imem_we !== 1'b1 || i2.imem_addr !== 12'd0 || i2.imem_data !== 32'h08000007) begin
      fails++; $display("FAIL full_rewrite: got we %b addr %0d data %h expected 1 0 08000007",
        i2.imem_we, i2.imem_addr, i2.imem_data); end
  endtask

  task automatic test_start_in_load();
    apply_reset();
    pulse_start();
    drive(5'b00100, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'd0, 1'b0);
    tick();
    start = 1'b1;
    drive(5'b00100, 5'd2, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'd0, 1'b0);
    tick();
    start = 1'b0;
    idle_bus();
    tests++; if (i0.imem_addr !== 12'd1 || i0.count !== 13'd2 || i0.imem_data !== 32'h20800000) begin
      fails++; $display("FAIL start_ignored: got addr %0d count %0d data %h expected 1 2 20800000",
        i0.imem_addr, i0.count, i0.imem_data); end
  endtask

  task automatic test_reset_mid_session();
    apply_reset();
    pulse_start();
    drive(5'b00100, 5'd3, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'd0, 1'b0);
    tick();
    reset = 1'b1;
    #1;
    tests++; if (i0.imem_we !== 1'b0 || i0.count !== 13'd0 || i0.busy !== 1'b0 || i0.imem_data !== 32'd0) begin
      fails++; $display("FAIL midreset_now: got we %b count %0d busy %b data %h expected 0 0 0 0",
        i0.imem_we, i0.count, i0.busy, i0.imem_data); end
    tick();
    reset = 1'b0;
    tick();
    tests++; if (i0.imem_we !== 1'b0 || i0.in_ready !== 1'b0 || i0.done !== 1'b0 || i0.imem_addr !== 12'd0) begin
      fails++; $display("FAIL midreset_after: got we %b ready %b done %b addr %0d expected 0 0 0 0",
        i0.imem_we, i0.in_ready, i0.done, i0.imem_addr); end
    idle_bus();
  endtask

  initial begin
    test_reset();
    test_single_r();
    test_back_to_back();
    test_field_masking();
    test_pad();
    test_bad_opcode();
    test_full();
    test_start_in_load();
    test_reset_mid_session();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/inst_encoder_loader.md
Name: inst_encoder_loader

Overview:
Reverse of the processor's instruction decode path. It accepts decoded instruction fields over a valid/ready stream and packs them into 32-bit ISA words in R / I / JI / JII format. It writes the words sequentially into the instruction memory write port, starting at a base address. It is used by the boot/test loader to fill imem before the core is released from stall, and can optionally pad the end of the program with nops.

Parameters:
ADDR_W, 12, imem word-address width
BASE_ADDR, 0, first word address written after start
DEPTH, 4096, number of writable words from BASE_ADDR (BASE_ADDR+DEPTH <= 2^ADDR_W)
PAD_NOPS, 0, number of zero words appended after the last instruction

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begins a load session (honoured in IDLE and DONE only)
in_valid  in  1  field bundle valid
in_ready  out  1  block can accept a bundle this cycle
in_last  in  1  bundle is the final program instruction
in_opcode  in  5  instruction opcode
in_rd / in_rs / in_rt  in  5 each  register fields
in_shamt  in  5  shift amount (R only)
in_aluop  in  5  ALU op (R only)
in_imm  in  17  immediate, raw two's complement (I only)
in_target  in  27  jump target (JI only)
imem_we  out  1  imem write strobe
imem_addr  out  ADDR_W  imem word address
imem_data  out  32  encoded word
busy  out  1  state is LOAD or PAD
done  out  1  state is DONE
err_opcode  out  1  sticky: unsupported opcode dropped
err_full  out  1  sticky: bundle offered while full
count  out  ADDR_W+1  words written this session, including pad

Behaviour:
- Reset: state IDLE. in_ready, imem_we, busy, done, err_* = 0. imem_addr = BASE_ADDR, imem_data = 0, count = 0. Reset mid-session aborts with no further writes.
- States and transitions:
  - IDLE: start -> LOAD; clears count and err_* and sets ptr = BASE_ADDR.
  - LOAD: in_ready = !full. An accept (in_valid & in_ready) with in_last -> PAD if PAD_NOPS > 0, else DONE.
  - PAD: writes one zero word per cycle, PAD_NOPS times, then -> DONE. Stops early at full with no error.
  - DONE: done = 1. start -> LOAD (new session, same clears as from IDLE).
  - start in LOAD/PAD is ignored.
- full = (count == DEPTH).
  - In LOAD with full & in_valid: err_full <= 1 and go to DONE next cycle. The bundle is not written.
- Write latency: a bundle accepted in cycle t is presented in cycle t+1 as imem_we = 1, imem_addr = ptr, imem_data = encoded word.
  - ptr and count increment at that edge; imem_we = 0 otherwise.
  - One word per cycle max; back-to-back accepts give a continuous write burst. The memory never stalls.
- Encoding, selected by opcode; unlisted bits are 0:
  - R, 00000: [31:27] = op, [26:22] = rd, [21:17] = rs, [16:12] = rt, [11:7] = shamt, [6:2] = aluop, [1:0] = 00.
  - I, 00101 addi / 00111 sw / 01000 lw / 00010 bne / 00110 blt: op, rd, rs, [16:0] = imm.
  - JI, 00001 j / 00011 jal / 10110 bex / 10101 setx: op, [26:0] = target.
  - JII, 00100 jr: op, [26:22] = rd.
- Any other opcode: the bundle is accepted (handshake completes) but not written. err_opcode <= 1; ptr and count are unchanged. If in_last is set, the state transition still occurs.
- Fields irrelevant to the format are ignored, never OR-ed in.
- Address arithmetic: ptr = BASE_ADDR + count, truncated to ADDR_W. No wrap within a session, because the full check precedes the write.

Decomposition:
- Shared package (isa_pkg): opcode constants (OP_ALU, OP_ADDI, OP_SW, OP_LW, OP_J, OP_BNE, OP_JAL, OP_JR, OP_BLT, OP_BEX, OP_SETX), field bit-position constants, and a format enum {FMT_R, FMT_I, FMT_JI, FMT_JII, FMT_BAD}.
- One combinational sub-module, inst_pack: opcode plus fields -> 32-bit word and format. The decoder's field positions are checked against it in the bench.
- FSM, counters and output registers live in inst_encoder_loader.

Test Plan:
- Single R word: start, then add rd=3, rs=1, rt=2, aluop=0 with in_last -> one write: addr 0, data 0x00C22000, then done = 1, count = 1.
- Burst of 4, in_valid held: sll rd4 rs2 shamt3 aluop4; addi rd5 rs0 imm 0x1FFFF; j target 100; jr rd31 (last) -> addrs 0..3, data 0x01040190, 0x2941FFFF, 0x08000064, 0x27C00000, with imem_we high four consecutive cycles.
- PAD_NOPS = 2, BASE_ADDR = 16: one addi then last -> writes at 16 (instr), 17 and 18 (0x00000000), count = 3, then done.
- Opcode 11111 mid-stream -> no write, err_opcode = 1; the next valid word lands at the next unused address.
- DEPTH = 2: offer 3 bundles -> 2 writes, then err_full = 1 and DONE. A later start restarts at BASE_ADDR with errors cleared.
- Reset asserted one cycle after an accept -> imem_we = 0 immediately and all outputs at reset values. Also: start during LOAD has no effect on ptr.
